// File: rtl/lsu_pkg.sv
// Shared types and RV32I funct3 encodings for the load/store unit.
// LSU_MISALIGN_TRAP_EN selects trapping vs. force-aligning misaligned accesses.
`timescale 1ns/1ps
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Only funct3[1:0] selects the size; the sign bit plays no part here.
    function automatic lsu_size_t decode_size(input logic is_store, input logic [2:0] f3);
        lsu_size_t sz;
        if (is_store) begin
            case ({1'b0, f3[1:0]})
                SB:      sz = SZ_BYTE;
                SH:      sz = SZ_HALF;
                SW:      sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                LB, LBU: sz = SZ_BYTE;
                LH, LHU: sz = SZ_HALF;
                LW:      sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes and replication, load lane select and extension.
// Misalignment is reported here; the top decides whether to trap or proceed.
`timescale 1ns/1ps
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [1:0]       offset,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [1:0]       eff_offset,
    output logic             misaligned,
    output logic [3:0]       wstrb,
    output logic [WIDTH-1:0] wdata_rep,
    output logic [WIDTH-1:0] rdata_ext
);

    lsu_size_t   size;
    logic        sext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        size       = decode_size(is_store, funct3);
        sext       = ~funct3[2];
        eff_offset = offset;
        misaligned = 1'b0;
        wstrb      = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = mem_rdata;
        lane_b     = mem_rdata[7:0];
        lane_h     = mem_rdata[15:0];
        case (size)
            SZ_BYTE: begin
                wstrb     = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                lane_b    = mem_rdata[{offset, 3'b000} +: 8];
                rdata_ext = {{24{sext & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                misaligned = offset[0];
                eff_offset = {offset[1], 1'b0};
                wstrb      = 4'b0011 << {offset[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                lane_h     = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
                rdata_ext  = {{16{sext & lane_h[15]}}, lane_h};
            end
            default: begin
                misaligned = (offset != 2'b00);
                eff_offset = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Single-outstanding load/store unit between the core and a word-wide memory port.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them.
`timescale 1ns/1ps
// state   | meaning
// IDLE    | waiting for start; the only state where start is sampled
// REQ     | mem_req asserted, request fields held until mem_ready
// DONE    | one-cycle completion, done (and misalign) valid
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
    output logic             misalign,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_t       state, state_nxt;
    logic [2:0]       funct3_q;
    logic [1:0]       offset_q;
    logic             trap;

    logic             al_is_store;
    logic [2:0]       al_funct3;
    logic [1:0]       al_offset;
    logic [1:0]       al_eff_offset;
    logic             al_misaligned;
    logic [3:0]       al_wstrb;
    logic [WIDTH-1:0] al_wdata;
    logic [WIDTH-1:0] al_rdata;

    // One aligner serves both phases: request encoding in IDLE, load extraction in REQ.
    always_comb begin
        al_is_store = is_store;
        al_funct3   = funct3;
        al_offset   = addr[1:0];
        if (state != ST_IDLE) begin
            al_is_store = mem_we;
            al_funct3   = funct3_q;
            al_offset   = offset_q;
        end
    end

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .is_store   (al_is_store),
        .funct3     (al_funct3),
        .offset     (al_offset),
        .wdata      (wdata),
        .mem_rdata  (mem_rdata),
        .eff_offset (al_eff_offset),
        .misaligned (al_misaligned),
        .wstrb      (al_wstrb),
        .wdata_rep  (al_wdata),
        .rdata_ext  (al_rdata)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap     = al_misaligned;
    assign misalign = done & misalign_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            misalign_q <= al_misaligned;
        end
    end
`else
    logic unused_misaligned;
    assign unused_misaligned = al_misaligned;
    assign trap              = 1'b0;
    assign misalign          = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = trap ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_ready) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            rdata     <= '0;
            funct3_q  <= 3'b000;
            offset_q  <= 2'b00;
        end else if (state == ST_IDLE && start) begin
            mem_req   <= ~trap;
            mem_we    <= is_store & ~trap;
            mem_addr  <= {addr[WIDTH-1:2], 2'b00};
            mem_wdata <= al_wdata;
            mem_wstrb <= (is_store && !trap) ? al_wstrb : 4'b0000;
            funct3_q  <= funct3;
            offset_q  <= al_eff_offset;
        end else if (state == ST_REQ && mem_ready) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            if (!mem_we) begin
                rdata <= al_rdata;
            end
        end
    end

endmodule
